// File: rtl/stim_capture_pkg.sv
// stim_capture_pkg: shared FSM states and MISR constants for the exhaustive stimulus/capture engine
package stim_capture_pkg;
  typedef enum logic [1:0] {IDLE, APPLY, EMIT, DONE} state_t;
  localparam int SIG_WIDTH = 16;
  localparam logic [SIG_WIDTH-1:0] MISR_POLY = 16'h1021;
endpackage

// File: rtl/stim_misr.sv
// stim_misr: 16-bit multiple-input signature register compacting accepted records
module stim_misr
  import stim_capture_pkg::*;
(
  input  logic                 CK,
  input  logic                 reset,
  input  logic                 clear,
  input  logic                 en,
  input  logic [SIG_WIDTH-1:0] data,
  output logic [SIG_WIDTH-1:0] sig
);
  // shift with polynomial feedback and fold in the record on each enable
  always_ff @(posedge CK)
    if (!reset || clear) sig <= '0;
    else if (en) sig <= {sig[SIG_WIDTH-2:0], 1'b0} ^ (sig[SIG_WIDTH-1] ? MISR_POLY : '0) ^ data;
endmodule

// File: rtl/exhaustive_stim_capture.sv
// exhaustive_stim_capture: sweeps all input patterns, samples the response after a settle time and emits records; STIM_MISR_EN adds a signature
module exhaustive_stim_capture
  import stim_capture_pkg::*;
#(
  parameter int N_WIDTH    = 5,
  parameter int OUT_WIDTH  = 1,
  parameter int SETTLE_CYC = 1
) (
  input  logic                 CK,
  input  logic                 reset,
  input  logic                 start,
  output logic [N_WIDTH-1:0]   dut_in,
  input  logic [OUT_WIDTH-1:0] dut_out,
  output logic                 rec_valid,
  input  logic                 rec_ready,
  output logic [N_WIDTH-1:0]   rec_pattern,
  output logic [OUT_WIDTH-1:0] rec_response,
  output logic                 busy,
  output logic                 done,
  output logic [SIG_WIDTH-1:0] signature
);
  localparam int CW = $clog2(SETTLE_CYC + 1);
  localparam logic [CW-1:0] SETTLE = CW'(SETTLE_CYC);
  state_t state, state_d;
  logic [CW-1:0] cnt, cnt_d;
  logic [N_WIDTH-1:0] dut_in_d, pat_d;
  logic [OUT_WIDTH-1:0] resp_d;
  logic valid_d, busy_d, done_d;
  // state and datapath registers; reset aborts any sweep on the same edge
  always_ff @(posedge CK)
    if (!reset) begin
      state        <= IDLE;
      cnt          <= '0;
      dut_in       <= '0;
      rec_pattern  <= '0;
      rec_response <= '0;
      rec_valid    <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      state        <= state_d;
      cnt          <= cnt_d;
      dut_in       <= dut_in_d;
      rec_pattern  <= pat_d;
      rec_response <= resp_d;
      rec_valid    <= valid_d;
      busy         <= busy_d;
      done         <= done_d;
    end
  // sweep sequencing: apply pattern, wait settle, hold record until accepted, advance
  always_comb begin
    state_d  = state;
    cnt_d    = cnt;
    dut_in_d = dut_in;
    pat_d    = rec_pattern;
    resp_d   = rec_response;
    valid_d  = rec_valid;
    busy_d   = busy;
    done_d   = done;
    case (state)
      IDLE, DONE: if (start) begin
        state_d  = APPLY;
        cnt_d    = SETTLE;
        dut_in_d = '0;
        busy_d   = 1'b1;
        done_d   = 1'b0;
      end
      APPLY: begin
        cnt_d = cnt - 1'b1;
        if (cnt == CW'(1)) begin
          state_d = EMIT;
          pat_d   = dut_in;
          resp_d  = dut_out;
          valid_d = 1'b1;
        end
      end
      EMIT: if (rec_ready) begin
        valid_d  = 1'b0;
        state_d  = &dut_in ? DONE : APPLY;
        done_d   = &dut_in;
        busy_d   = ~&dut_in;
        dut_in_d = &dut_in ? dut_in : dut_in + 1'b1;
        cnt_d    = &dut_in ? cnt : SETTLE;
      end
      default: state_d = IDLE;
    endcase
  end
`ifdef STIM_MISR_EN
  logic misr_en, misr_clr;
  logic [SIG_WIDTH-1:0] misr_data;
  assign misr_en   = state == EMIT && rec_ready;
  assign misr_clr  = start && (state == IDLE || state == DONE);
  assign misr_data = SIG_WIDTH'({rec_pattern, rec_response});
  stim_misr u_misr (
    .CK   (CK),
    .reset(reset),
    .clear(misr_clr),
    .en   (misr_en),
    .data (misr_data),
    .sig  (signature)
  );
`else
  assign signature = '0;
`endif
endmodule

// File: tb/tb_exhaustive_stim_capture.sv
// tb_exhaustive_stim_capture: scoreboard bench for the sweep engine with a parity circuit and a delayed parity circuit
module tb_exhaustive_stim_capture;
  logic CK = 1'b0;
  logic reset, start, rec_ready, start3;
  logic [4:0] dut_in, rec_pattern, dut_in3, rec_pattern3;
  logic [0:0] dut_out, rec_response, dut_out3, rec_response3;
  logic rec_valid, busy, done, rec_valid3, busy3, done3;
  logic [15:0] signature, signature3;
  logic d1, d2;
  logic [5:0] q[$];
  logic [5:0] q3[$];
  logic [15:0] sig_m = '0;
  logic [15:0] sig_first;
  bit sig_pend = 0;
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last3 = -1;

  always #5 CK = ~CK;

  assign dut_out  = ^dut_in;
  assign dut_out3 = d2;

  always @(posedge CK) begin
    d1 <= ^dut_in3;
    d2 <= d1;
    cyc <= cyc + 1;
  end

  exhaustive_stim_capture u_dut (
    .CK(CK), .reset(reset), .start(start), .dut_in(dut_in), .dut_out(dut_out),
    .rec_valid(rec_valid), .rec_ready(rec_ready), .rec_pattern(rec_pattern),
    .rec_response(rec_response), .busy(busy), .done(done), .signature(signature)
  );

  exhaustive_stim_capture #(.SETTLE_CYC(3)) u_dut3 (
    .CK(CK), .reset(reset), .start(start3), .dut_in(dut_in3), .dut_out(dut_out3),
    .rec_valid(rec_valid3), .rec_ready(1'b1), .rec_pattern(rec_pattern3),
    .rec_response(rec_response3), .busy(busy3), .done(done3), .signature(signature3)
  );

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  // record monitor: a handshake happens on the next posedge, so compare and advance the model here
  always @(negedge CK) begin
    logic [5:0] e;
`ifdef STIM_MISR_EN
    if (sig_pend) chk("signature", signature, sig_m);
`endif
    sig_pend = 0;
    if (rec_valid && rec_ready) begin
      chk("rec_expected", int'(q.size() > 0), 1);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("rec_pattern", rec_pattern, e[5:1]);
        chk("rec_response", rec_response, e[0]);
        sig_m = {sig_m[14:0], 1'b0} ^ (sig_m[15] ? 16'h1021 : 16'h0) ^ {10'b0, e};
        sig_pend = 1;
      end
    end
  end

  always @(negedge CK) begin
    logic [5:0] e;
    if (rec_valid3) begin
      chk("rec3_expected", int'(q3.size() > 0), 1);
      if (q3.size() > 0) begin
        e = q3.pop_front();
        chk("rec3_pattern", rec_pattern3, e[5:1]);
        chk("rec3_response", rec_response3, e[0]);
      end
      if (last3 >= 0) chk("rec3_gap", cyc - last3, 4);
      last3 = cyc;
    end
  end

  task automatic push_all();
    for (int p = 0; p < 32; p++) begin
      logic [4:0] v;
      v = p[4:0];
      q.push_back({v, ^v});
    end
  endtask

  task automatic run_sweep(input int stall_pat, input bit ign, input int exp_cyc);
    int n, st;
    push_all();
    sig_m = '0;
    start = 1'b1;
    @(posedge CK); #1;
    start = 1'b0;
    chk("start_busy", busy, 1);
    chk("start_done_clr", done, 0);
    n = 0;
    st = 0;
    while (!done && n < exp_cyc + 50) begin
      @(posedge CK); #1;
      n++;
      start = ign && (n == 10 || n == 11);
      if (stall_pat >= 0 && rec_valid && int'(rec_pattern) == stall_pat && st < 3) begin
        if (st > 0) begin
          chk("bp_valid", rec_valid, 1);
          chk("bp_pattern", rec_pattern, stall_pat);
          chk("bp_response", rec_response, 0);
          chk("bp_dut_in", dut_in, stall_pat);
        end
        rec_ready = 1'b0;
        st++;
      end else rec_ready = 1'b1;
    end
    start = 1'b0;
    rec_ready = 1'b1;
    chk("sweep_cycles", n, exp_cyc);
    chk("end_done", done, 1);
    chk("end_busy", busy, 0);
    chk("end_dut_in", dut_in, 31);
    chk("queue_drained", q.size(), 0);
  endtask

  initial begin
    int n;
    reset = 1'b0;
    start = 1'b0;
    start3 = 1'b0;
    rec_ready = 1'b1;
    repeat (3) @(posedge CK);
    #1;
    chk("rst_dut_in", dut_in, 0);
    chk("rst_valid", rec_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_sig", signature, 0);
    reset = 1'b1;
    @(posedge CK); #1;
    run_sweep(-1, 1'b1, 64);
    sig_first = signature;
    repeat (3) @(posedge CK);
    #1;
    chk("done_held", done, 1);
    chk("done_idle_busy", busy, 0);
`ifdef STIM_MISR_EN
    chk("sig_final", signature, sig_m);
`else
    chk("sig_off", signature, 0);
`endif
    run_sweep(5, 1'b0, 67);
`ifdef STIM_MISR_EN
    chk("sig_rerun", signature, sig_first);
`endif
    push_all();
    start = 1'b1;
    @(posedge CK); #1;
    start = 1'b0;
    n = 0;
    while (dut_in != 5'd12 && n < 100) begin
      @(posedge CK); #1;
      n++;
    end
    chk("abort_reached", int'(dut_in), 12);
    reset = 1'b0;
    @(posedge CK); #1;
    chk("abort_dut_in", dut_in, 0);
    chk("abort_pattern", rec_pattern, 0);
    chk("abort_response", rec_response, 0);
    chk("abort_valid", rec_valid, 0);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_sig", signature, 0);
    q.delete();
    reset = 1'b1;
    repeat (2) @(posedge CK);
    #1;
    chk("idle_stays", busy, 0);
    run_sweep(-1, 1'b0, 64);
    for (int p = 0; p < 32; p++) begin
      logic [4:0] v;
      v = p[4:0];
      q3.push_back({v, ^v});
    end
    start3 = 1'b1;
    @(posedge CK); #1;
    start3 = 1'b0;
    n = 0;
    while (!done3 && n < 300) begin
      @(posedge CK); #1;
      n++;
    end
    chk("sweep3_cycles", n, 128);
    chk("sweep3_done", done3, 1);
    chk("queue3_drained", q3.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
